// File: rtl/light_path_gen_if.sv
// Light position bus: three axis coordinates plus a one-cycle valid strobe.
// Latency: none, wires only; no backpressure, the consumer must take the strobe when it fires.
`ifndef LOC_WIDTH
`define LOC_WIDTH 8
`endif

interface light_path_gen_if;
    logic [`LOC_WIDTH-1:0] l_loc_x_o;
    logic [`LOC_WIDTH-1:0] l_loc_y_o;
    logic [`LOC_WIDTH-1:0] l_loc_z_o;
    logic                  l_loc_vld_o;

    modport master (output l_loc_x_o, l_loc_y_o, l_loc_z_o, l_loc_vld_o);
    modport slave  (input  l_loc_x_o, l_loc_y_o, l_loc_z_o, l_loc_vld_o);
endinterface

// File: rtl/light_path_gen.sv
// Bouncing light position, stepped once per FRAME_DIV vsync edges; LIGHT_HOLD_EN adds hold_i to freeze a step.
// Latency: strobe 2 cycles after the edge is seen; no backpressure, edges during UPDATE/EMIT are dropped.
`ifndef LOC_WIDTH
`define LOC_WIDTH 8
`endif

module light_path_gen #(
    parameter int LOC_MIN   = 0,
    parameter int LOC_MAX   = 2**`LOC_WIDTH-1,
    parameter int STEP_X    = 4,
    parameter int STEP_Y    = 2,
    parameter int STEP_Z    = 1,
    parameter int FRAME_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync_i,
    input  logic             run_i,
`ifdef LIGHT_HOLD_EN
    input  logic             hold_i,
`endif
    light_path_gen_if.master loc_if
);

    localparam int W  = `LOC_WIDTH;
    localparam int W1 = W + 1;
    localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    typedef logic [W-1:0] loc_t;
    typedef logic [W:0]   ext_t;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_UPDATE, S_EMIT} state_t;

    localparam ext_t MIN_E  = W1'(LOC_MIN);
    localparam ext_t MAX_E  = W1'(LOC_MAX);
    localparam ext_t STEP_XE = W1'(STEP_X);
    localparam ext_t STEP_YE = W1'(STEP_Y);
    localparam ext_t STEP_ZE = W1'(STEP_Z);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);

    // Returns {new_dir, new_pos}; the extra bit keeps pos+step from wrapping.
    function automatic ext_t step_axis(input loc_t pos, input logic dir, input ext_t step);
        ext_t p;
        ext_t sum;
        ext_t res;
        p   = {1'b0, pos};
        sum = p + step;
        if (dir) begin
            if (sum > MAX_E) res = {1'b0, MAX_E[W-1:0]};
            else             res = {1'b1, sum[W-1:0]};
        end else begin
            sum = p - step;
            if (p < MIN_E + step) res = {1'b1, MIN_E[W-1:0]};
            else                  res = {1'b0, sum[W-1:0]};
        end
        return res;
    endfunction

    state_t        state_q;
    logic          vsync_q;
    logic [CW-1:0] cnt_q;
    loc_t          pos_x_q, pos_y_q, pos_z_q;
    logic          dir_x_q, dir_y_q, dir_z_q;
    logic          vld_q;

    ext_t axis_x_d, axis_y_d, axis_z_d;
    logic frame_edge;
    logic hold_w;

`ifdef LIGHT_HOLD_EN
    assign hold_w = hold_i;
`else
    assign hold_w = 1'b0;
`endif

    assign frame_edge = vsync_i & ~vsync_q;
    assign axis_x_d   = step_axis(pos_x_q, dir_x_q, STEP_XE);
    assign axis_y_d   = step_axis(pos_y_q, dir_y_q, STEP_YE);
    assign axis_z_d   = step_axis(pos_z_q, dir_z_q, STEP_ZE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vsync_q <= 1'b0;
            cnt_q   <= '0;
            pos_x_q <= MIN_E[W-1:0];
            pos_y_q <= MIN_E[W-1:0];
            pos_z_q <= MIN_E[W-1:0];
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
            dir_z_q <= 1'b1;
            vld_q   <= 1'b0;
        end else begin
            vsync_q <= vsync_i;
            vld_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (run_i) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Dropping run wins over a coincident edge so a stop is never followed by a stray step.
                    if (!run_i) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (frame_edge) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= S_UPDATE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                S_UPDATE: begin
                    if (!hold_w) begin
                        pos_x_q <= axis_x_d[W-1:0];
                        pos_y_q <= axis_y_d[W-1:0];
                        pos_z_q <= axis_z_d[W-1:0];
                        dir_x_q <= axis_x_d[W];
                        dir_y_q <= axis_y_d[W];
                        dir_z_q <= axis_z_d[W];
                    end
                    vld_q   <= 1'b1;
                    state_q <= S_EMIT;
                end
                S_EMIT: begin
                    state_q <= run_i ? S_WAIT : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign loc_if.l_loc_x_o   = pos_x_q;
    assign loc_if.l_loc_y_o   = pos_y_q;
    assign loc_if.l_loc_z_o   = pos_z_q;
    assign loc_if.l_loc_vld_o = vld_q;

endmodule

// File: tb/tb_light_path_gen.sv
// Directed bench: dut_a bounces X in 0..100 by 30 per frame, dut_b divides frames by 3.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_light_path_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic vsync = 1'b0;
    logic run   = 1'b0;
`ifdef LIGHT_HOLD_EN
    logic hold  = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    light_path_gen_if ifa();
    light_path_gen_if ifb();

    light_path_gen #(
        .LOC_MIN(0), .LOC_MAX(100), .STEP_X(30), .STEP_Y(2), .STEP_Z(1), .FRAME_DIV(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .vsync_i(vsync), .run_i(run),
`ifdef LIGHT_HOLD_EN
        .hold_i(hold),
`endif
        .loc_if(ifa.master)
    );

    light_path_gen #(
        .FRAME_DIV(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .vsync_i(vsync), .run_i(run),
`ifdef LIGHT_HOLD_EN
        .hold_i(hold),
`endif
        .loc_if(ifb.master)
    );

    task automatic do_reset(input bit start_run);
        @(negedge clk);
        rst_n = 1'b0;
        vsync = 1'b0;
        run   = 1'b0;
`ifdef LIGHT_HOLD_EN
        hold  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run = start_run;
        repeat (2) @(negedge clk);
    endtask

    // One-cycle vsync pulse, then count strobe cycles of each DUT over a window.
    task automatic edge_and_watch(output int na, output int nb);
        na = 0;
        nb = 0;
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ifa.l_loc_vld_o === 1'b1) na++;
            if (ifb.l_loc_vld_o === 1'b1) nb++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        run   = 1'b1;
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        checks++; if (ifa.l_loc_vld_o !== 1'b0) begin failures++; $display("FAIL reset_vld_a: got %b expected 0", ifa.l_loc_vld_o); end
        checks++; if (ifb.l_loc_vld_o !== 1'b0) begin failures++; $display("FAIL reset_vld_b: got %b expected 0", ifb.l_loc_vld_o); end
        checks++; if (ifa.l_loc_x_o !== 0) begin failures++; $display("FAIL reset_x_a: got %0d expected 0", ifa.l_loc_x_o); end
        checks++; if (ifa.l_loc_y_o !== 0) begin failures++; $display("FAIL reset_y_a: got %0d expected 0", ifa.l_loc_y_o); end
        checks++; if (ifa.l_loc_z_o !== 0) begin failures++; $display("FAIL reset_z_a: got %0d expected 0", ifa.l_loc_z_o); end
        checks++; if (ifb.l_loc_x_o !== 0) begin failures++; $display("FAIL reset_x_b: got %0d expected 0", ifb.l_loc_x_o); end
    endtask

    task automatic test_run_idle;
        int na, nb, ta, tb;
        ta = 0;
        tb = 0;
        do_reset(1'b0);
        repeat (10) begin
            edge_and_watch(na, nb);
            ta += na;
            tb += nb;
        end
        checks++; if (ta !== 0) begin failures++; $display("FAIL idle_strobes_a: got %0d expected 0", ta); end
        checks++; if (tb !== 0) begin failures++; $display("FAIL idle_strobes_b: got %0d expected 0", tb); end
        checks++; if (ifa.l_loc_x_o !== 0) begin failures++; $display("FAIL idle_x_a: got %0d expected 0", ifa.l_loc_x_o); end
        checks++; if (ifb.l_loc_z_o !== 0) begin failures++; $display("FAIL idle_z_b: got %0d expected 0", ifb.l_loc_z_o); end
    endtask

    task automatic test_bounce;
        int exp_x[5] = '{30, 60, 90, 100, 70};
        int exp_y[5] = '{2, 4, 6, 8, 10};
        int na, nb, tb;
        tb = 0;
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            edge_and_watch(na, nb);
            tb += nb;
            checks++; if (na !== 1) begin failures++; $display("FAIL bounce_strobe_%0d: got %0d cycles expected 1", i, na); end
            checks++; if (ifa.l_loc_x_o !== exp_x[i]) begin failures++; $display("FAIL bounce_x_%0d: got %0d expected %0d", i, ifa.l_loc_x_o, exp_x[i]); end
            checks++; if (ifa.l_loc_y_o !== exp_y[i]) begin failures++; $display("FAIL bounce_y_%0d: got %0d expected %0d", i, ifa.l_loc_y_o, exp_y[i]); end
        end
        checks++; if (ifa.l_loc_z_o !== 5) begin failures++; $display("FAIL bounce_z: got %0d expected 5", ifa.l_loc_z_o); end
        checks++; if (tb !== 1) begin failures++; $display("FAIL bounce_div_strobes: got %0d expected 1", tb); end
        checks++; if (ifb.l_loc_x_o !== 4) begin failures++; $display("FAIL bounce_div_x: got %0d expected 4", ifb.l_loc_x_o); end
    endtask

    task automatic test_frame_div;
        int na, nb, tb, exp_nb;
        tb = 0;
        do_reset(1'b1);
        for (int i = 1; i <= 9; i++) begin
            edge_and_watch(na, nb);
            tb += nb;
            exp_nb = (i % 3 == 0) ? 1 : 0;
            checks++; if (nb !== exp_nb) begin failures++; $display("FAIL div_edge_%0d: got %0d strobe cycles expected %0d", i, nb, exp_nb); end
        end
        checks++; if (tb !== 3) begin failures++; $display("FAIL div_total: got %0d expected 3", tb); end
        checks++; if (ifb.l_loc_x_o !== 12) begin failures++; $display("FAIL div_x: got %0d expected 12", ifb.l_loc_x_o); end
        checks++; if (ifb.l_loc_y_o !== 6) begin failures++; $display("FAIL div_y: got %0d expected 6", ifb.l_loc_y_o); end
        checks++; if (ifb.l_loc_z_o !== 3) begin failures++; $display("FAIL div_z: got %0d expected 3", ifb.l_loc_z_o); end
    endtask

    task automatic test_vsync_held;
        int cnt;
        cnt = 0;
        do_reset(1'b1);
        vsync = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (ifa.l_loc_vld_o === 1'b1) cnt++;
        end
        vsync = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ifa.l_loc_vld_o === 1'b1) cnt++;
        end
        checks++; if (cnt !== 1) begin failures++; $display("FAIL held_strobes: got %0d expected 1", cnt); end
        checks++; if (ifa.l_loc_x_o !== 30) begin failures++; $display("FAIL held_x: got %0d expected 30", ifa.l_loc_x_o); end
    endtask

    task automatic test_reset_in_emit;
        int na, nb, cnt;
        bit seen;
        seen = 1'b0;
        cnt  = 0;
        do_reset(1'b1);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (ifa.l_loc_vld_o === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL emit_seen: got no strobe within 10 cycles expected one"); end
        rst_n = 1'b0;
        #1;
        checks++; if (ifa.l_loc_vld_o !== 1'b0) begin failures++; $display("FAIL emit_rst_vld: got %b expected 0", ifa.l_loc_vld_o); end
        checks++; if (ifa.l_loc_x_o !== 0) begin failures++; $display("FAIL emit_rst_x: got %0d expected 0", ifa.l_loc_x_o); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (ifa.l_loc_vld_o === 1'b1) cnt++;
        end
        checks++; if (cnt !== 0) begin failures++; $display("FAIL emit_rst_nostrobe: got %0d expected 0", cnt); end
        edge_and_watch(na, nb);
        checks++; if (na !== 1) begin failures++; $display("FAIL emit_rst_next: got %0d expected 1", na); end
        checks++; if (ifa.l_loc_x_o !== 30) begin failures++; $display("FAIL emit_rst_next_x: got %0d expected 30", ifa.l_loc_x_o); end
    endtask

    task automatic test_run_drop;
        int na, nb, ta, tb;
        ta = 0;
        tb = 0;
        do_reset(1'b1);
        repeat (2) edge_and_watch(na, nb);
        vsync = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        vsync = 1'b0;
        run   = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (ifa.l_loc_vld_o === 1'b1) ta++;
        end
        checks++; if (ta !== 0) begin failures++; $display("FAIL drop_edge_ignored: got %0d expected 0", ta); end
        repeat (2) begin
            edge_and_watch(na, nb);
            tb += nb;
        end
        checks++; if (tb !== 0) begin failures++; $display("FAIL drop_cnt_cleared: got %0d expected 0", tb); end
        edge_and_watch(na, nb);
        checks++; if (nb !== 1) begin failures++; $display("FAIL drop_third_edge: got %0d expected 1", nb); end
        checks++; if (ifa.l_loc_x_o !== 70) begin failures++; $display("FAIL drop_x_a: got %0d expected 70", ifa.l_loc_x_o); end
    endtask

`ifdef LIGHT_HOLD_EN
    task automatic test_hold;
        int na, nb;
        do_reset(1'b1);
        repeat (2) edge_and_watch(na, nb);
        checks++; if (ifa.l_loc_x_o !== 60) begin failures++; $display("FAIL hold_pre_x: got %0d expected 60", ifa.l_loc_x_o); end
        hold = 1'b1;
        edge_and_watch(na, nb);
        checks++; if (na !== 1) begin failures++; $display("FAIL hold_strobe: got %0d expected 1", na); end
        checks++; if (ifa.l_loc_x_o !== 60) begin failures++; $display("FAIL hold_x: got %0d expected 60", ifa.l_loc_x_o); end
        hold = 1'b0;
        edge_and_watch(na, nb);
        checks++; if (ifa.l_loc_x_o !== 90) begin failures++; $display("FAIL hold_release_x: got %0d expected 90", ifa.l_loc_x_o); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: got no finish by 200000 expected earlier finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_run_idle();
        test_bounce();
        test_frame_div();
        test_vsync_held();
        test_reset_in_emit();
        test_run_drop();
`ifdef LIGHT_HOLD_EN
        test_hold();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
